// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : Hazard-controller bundle: ID/EX hazard inputs, EX branch
//            decision, front-end stall, pipeline enables and counters.
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rn_ifid;
    logic [REG_AW-1:0] rm_ifid;
    logic              rn_used;
    logic              rm_used;
    logic [REG_AW-1:0] rd_idex;
    logic              mem_read_en_idex;
    logic              pc_src_ex;
    logic              ext_stall;
    logic              pc_write_en;
    logic              if_id_write_en;
    logic              if_id_flush;
    logic              id_ex_nop;
    logic              stall_busy;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    modport master (
        output rn_ifid, rm_ifid, rn_used, rm_used, rd_idex,
               mem_read_en_idex, pc_src_ex, ext_stall,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_nop,
               stall_busy, stall_cycles, flush_events
    );

    modport slave (
        input  rn_ifid, rm_ifid, rn_used, rm_used, rd_idex,
               mem_read_en_idex, pc_src_ex, ext_stall,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_nop,
               stall_busy, stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Load-use / taken-branch hazard controller with multi-cycle stall
//            and flush, external freeze and saturating perf counters.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_AW            = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_DEPTH       = 1,
    parameter int ZERO_REG_EXEMPT   = 1,
    parameter int CNT_W             = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LU_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;

    localparam logic [2:0] c_load_rem  = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
    localparam logic [2:0] c_flush_rem = (FLUSH_DEPTH > 1)       ? 3'(FLUSH_DEPTH - 2)       : 3'd0;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [1:0]       r_state;
    logic [2:0]       r_rem;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    logic [1:0]       w_next_state;
    logic [2:0]       w_next_rem;
    logic             w_lu_hit;
    logic             w_zero_exempt;
    logic             w_do_stall;
    logic             w_do_flush;
    logic             w_do_ext;
    logic             w_pc_write_en;

    assign w_zero_exempt = (ZERO_REG_EXEMPT != 0) && (hz.rd_idex == '0);
    assign w_lu_hit      = hz.mem_read_en_idex && !w_zero_exempt &&
                           ((hz.rn_used && (hz.rd_idex == hz.rn_ifid)) ||
                            (hz.rm_used && (hz.rd_idex == hz.rm_ifid)));

    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_rem;
        w_do_stall   = 1'b0;
        w_do_flush   = 1'b0;
        w_do_ext     = 1'b0;
        if (hz.pc_src_ex) begin
            // A taken branch overrides everything, including an in-flight stall.
            w_do_flush = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                w_next_state = S_FLUSH;
                w_next_rem   = c_flush_rem;
            end else begin
                w_next_state = S_IDLE;
                w_next_rem   = 3'd0;
            end
        end else if (hz.ext_stall) begin
            // Freeze: state and rem hold, and the freeze output set is used in every state.
            w_do_ext = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lu_hit) begin
                        w_do_stall = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_next_state = S_LU_STALL;
                            w_next_rem   = c_load_rem;
                        end
                    end
                end
                S_LU_STALL: begin
                    w_do_stall = 1'b1;
                    if (r_rem == 3'd0) w_next_state = S_IDLE;
                    else               w_next_rem   = r_rem - 3'd1;
                end
                S_FLUSH: begin
                    w_do_flush = 1'b1;
                    if (r_rem == 3'd0) w_next_state = S_IDLE;
                    else               w_next_rem   = r_rem - 3'd1;
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_rem   = 3'd0;
                end
            endcase
        end
    end

    assign w_pc_write_en     = !rst_n || !(w_do_stall || w_do_ext);
    assign hz.pc_write_en    = w_pc_write_en;
    assign hz.if_id_write_en = w_pc_write_en;
    assign hz.id_ex_nop      = rst_n && (w_do_stall || w_do_flush || w_do_ext);
    assign hz.if_id_flush    = rst_n && w_do_flush;
    assign hz.stall_busy     = rst_n && (r_state != S_IDLE);
    assign hz.stall_cycles   = r_stall_cycles;
    assign hz.flush_events   = r_flush_events;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_pc_write_en && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            if (hz.pc_src_ex && (r_flush_events != '1))
                r_flush_events <= r_flush_events + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the pipelined ARM core: next generation of the combinational load-use/branch hazard detector. Adds a configurable multi-cycle load-use stall, multi-cycle branch flush, an external front-end stall request, operand-valid qualification and saturating performance counters. Sits between the ID/EX pipeline register, the EX branch resolver and the PC / IF/ID / ID/EX register enables.

## Interface
Parameters:
- REG_AW, 4: register-specifier width.
- LOAD_STALL_CYCLES, 1: stall cycles per load-use hazard. Legal range 1..7.
- FLUSH_DEPTH, 1: cycles of bubble insertion per taken branch. Legal range 1..3.
- ZERO_REG_EXEMPT, 1: when 1, rd_idex == 0 never raises a load-use hazard.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rn_ifid  in  REG_AW  Rn of the instruction in ID.
- rm_ifid  in  REG_AW  Rm of the instruction in ID.
- rn_used  in  1  the ID instruction reads Rn.
- rm_used  in  1  the ID instruction reads Rm.
- rd_idex  in  REG_AW  Rd of the instruction in ID/EX.
- mem_read_en_idex  in  1  the ID/EX instruction is a load.
- pc_src_ex  in  1  taken-branch decision from EX.
- ext_stall  in  1  external front-end freeze (e.g. I-mem not ready).
- pc_write_en  out  1  PC update enable.
- if_id_write_en  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to a NOP.
- id_ex_nop  out  1  insert a bubble into ID/EX.
- stall_busy  out  1  FSM is in LU_STALL or FLUSH.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write_en = 0.
- flush_events  out  CNT_W  saturating count of accepted pc_src_ex pulses.

## Operation
- lu_hit = mem_read_en_idex & !(ZERO_REG_EXEMPT & rd_idex == 0) & ((rn_used & rd_idex == rn_ifid) | (rm_used & rd_idex == rm_ifid)).
- FSM states: IDLE, LU_STALL, FLUSH. A down-counter rem (3 bits) holds the cycles remaining after the current one.
- IDLE:
  - pc_src_ex: flush outputs this cycle. If FLUSH_DEPTH > 1, go to FLUSH with rem = FLUSH_DEPTH-2.
  - Else lu_hit: stall outputs this cycle. If LOAD_STALL_CYCLES > 1, go to LU_STALL with rem = LOAD_STALL_CYCLES-2.
  - Else: all enables 1, nop/flush 0.
- LU_STALL:
  - Stall outputs regardless of lu_hit.
  - rem == 0 returns to IDLE; otherwise rem decrements.
  - pc_src_ex aborts the stall and is handled exactly as in IDLE.
- FLUSH:
  - Flush outputs.
  - rem == 0 returns to IDLE; otherwise rem decrements.
  - lu_hit is ignored.
  - A new pc_src_ex restarts the flush with rem = FLUSH_DEPTH-2, or returns to IDLE if FLUSH_DEPTH = 1.
- Output sets:
  - Stall: pc_write_en = 0, if_id_write_en = 0, id_ex_nop = 1, if_id_flush = 0.
  - Flush: pc_write_en = 1, if_id_write_en = 1, id_ex_nop = 1, if_id_flush = 1.
- Priority: pc_src_ex > ext_stall > lu_hit / LU_STALL.
- ext_stall with no pc_src_ex:
  - Forces pc_write_en = 0 and if_id_write_en = 0, and id_ex_nop = 1.
  - FSM and rem freeze, and a new lu_hit is not latched.
  - When ext_stall drops, the frozen state resumes.
- Counters:
  - stall_cycles increments on every cycle with pc_write_en = 0.
  - flush_events increments on every cycle with pc_src_ex = 1.
  - Both saturate at all-ones and never wrap.
- stall_busy = (state != IDLE).

## Timing
- All hazard outputs are combinational from state and inputs, so a detection cycle acts in the same cycle (zero latency). State, rem and counters update on the rising edge of clk.
- Load-use hazard detected in cycle T, with LOAD_STALL_CYCLES = N:
  - pc_write_en = 0 and id_ex_nop = 1 in cycles T..T+N-1.
  - Released in T+N.
- Taken branch in cycle T, with FLUSH_DEPTH = D: if_id_flush = 1 and id_ex_nop = 1 in cycles T..T+D-1.
- Reset (rst_n low, asynchronous):
  - Registered state: IDLE, rem = 0, stall_cycles = 0, flush_events = 0.
  - Combinational outputs forced: pc_write_en = 1, if_id_write_en = 1, id_ex_nop = 0, if_id_flush = 0, stall_busy = 0.
  - Reset asserted mid-stall or mid-flush aborts immediately. The first edge after deassertion starts from IDLE.
- Simultaneous lu_hit and pc_src_ex in IDLE: flush wins, and no stall cycle occurs.

## Test plan
- N=1, D=1: load to r3 in ID/EX, ID reads Rn=r3 with rn_used=1 -> one cycle of pc_write_en=0 and id_ex_nop=1; stall_cycles=1.
- N=3: same hazard at cycle 10 -> pc_write_en=0 in cycles 10,11,12 and 1 in cycle 13; stall_busy=1 in cycles 11,12; stall_cycles=3.
- rd_idex=0 with ZERO_REG_EXEMPT=1 -> no stall. rm match with rm_used=0 -> no stall.
- D=2: pc_src_ex pulse at cycle 5 during an N=3 stall entered at cycle 4 -> stall aborts; if_id_flush=1 in cycles 5,6; pc_write_en=1 in cycle 5; flush_events=1.
- ext_stall high for cycles 20-22 while in LU_STALL with rem=1 -> FSM frozen; stall resumes for 2 cycles after ext_stall drops; stall_cycles advances by 5.
- Force stall_cycles to 0xFFFE (CNT_W=16), then 3 stall cycles -> holds 0xFFFF. rst_n low mid-FLUSH -> outputs return to reset values immediately and counters read 0.
